// File: rtl/adsr_envelope.sv
// rtl/adsr_envelope.sv - per-voice ADSR envelope with tick prescaler and registered duty scaling
// Optional env_done pulse output enabled by defining ADSR_DONE_PULSE_EN.
module adsr_envelope #(
    parameter int PRESCALE  = 256,
    parameter int LEVEL_MAX = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        gate,
    input  logic [7:0]  attack_rate,
    input  logic [7:0]  decay_rate,
    input  logic [7:0]  sustain_level,
    input  logic [7:0]  release_rate,
    input  logic [15:0] duty_in,
    output logic [15:0] duty_out,
    output logic [7:0]  env_level,
    output logic [2:0]  env_state,
`ifdef ADSR_DONE_PULSE_EN
    output logic        env_done,
`endif
    output logic        active
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
    localparam logic [8:0]    LVL_MAX9 = 9'(LEVEL_MAX);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic        gate_q, gate_d;
    logic [15:0] duty_q, duty_d;
    logic        done_q, done_d;

    logic              tick;
    logic              rise;
    logic [8:0]        att_sum;
    logic signed [8:0] dec_diff;
    logic [23:0]       product;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            level_q <= 8'd0;
            cnt_q   <= '0;
            gate_q  <= 1'b0;
            duty_q  <= 16'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            gate_q  <= gate_d;
            duty_q  <= duty_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        tick     = (cnt_q == CNT_LAST);
        cnt_d    = tick ? '0 : cnt_q + 1'b1;
        gate_d   = gate;
        rise     = gate & ~gate_q;
        att_sum  = {1'b0, level_q} + {1'b0, attack_rate};
        dec_diff = $signed({1'b0, level_q}) - $signed({1'b0, decay_rate});
        product  = {8'd0, duty_in} * {16'd0, level_q};
        duty_d   = product[23:8];
        state_d  = state_q;
        level_d  = level_q;

        // Retrigger beats release, release beats tick arithmetic.
        if (rise) begin
            state_d = ATTACK;
        end else if (!gate && (state_q == ATTACK || state_q == DECAY || state_q == SUSTAIN)) begin
            state_d = RELEASE;
        end else begin
            case (state_q)
                IDLE: level_d = 8'd0;
                ATTACK: if (tick) begin
                    if (att_sum >= LVL_MAX9) begin
                        level_d = LVL_MAX9[7:0];
                        state_d = DECAY;
                    end else begin
                        level_d = att_sum[7:0];
                    end
                end
                DECAY: if (tick) begin
                    if (dec_diff <= $signed({1'b0, sustain_level})) begin
                        level_d = sustain_level;
                        state_d = SUSTAIN;
                    end else begin
                        level_d = dec_diff[7:0];
                    end
                end
                SUSTAIN: level_d = sustain_level;
                RELEASE: if (tick) begin
                    if (release_rate >= level_q) begin
                        level_d = 8'd0;
                        state_d = IDLE;
                    end else begin
                        level_d = level_q - release_rate;
                    end
                end
                default: begin
                    state_d = IDLE;
                    level_d = 8'd0;
                end
            endcase
        end

        // A coinciding rise redirects state_d to ATTACK, which suppresses the pulse.
        done_d = (state_q == RELEASE) && (state_d == IDLE);
    end

    always_comb begin
        env_state = state_q;
        env_level = level_q;
        duty_out  = duty_q;
        active    = (state_q != IDLE);
`ifdef ADSR_DONE_PULSE_EN
        env_done  = done_q;
`endif
    end

endmodule

// File: tb/tb_adsr_envelope.sv
// tb/tb_adsr_envelope.sv - directed self-checking bench for adsr_envelope
module tb_adsr_envelope;

    localparam int PRE = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        gate;
    logic [7:0]  attack_rate, decay_rate, sustain_level, release_rate;
    logic [15:0] duty_in;
    logic [15:0] duty_out;
    logic [7:0]  env_level;
    logic [2:0]  env_state;
    logic        active;
`ifdef ADSR_DONE_PULSE_EN
    logic        env_done;
`endif

    int checks = 0;
    int errors = 0;
    int pc = 0;
    bit was_tick;

    adsr_envelope #(.PRESCALE(PRE), .LEVEL_MAX(255)) dut (
        .clk(clk),
        .reset(reset),
        .gate(gate),
        .attack_rate(attack_rate),
        .decay_rate(decay_rate),
        .sustain_level(sustain_level),
        .release_rate(release_rate),
        .duty_in(duty_in),
        .duty_out(duty_out),
        .env_level(env_level),
        .env_state(env_state),
`ifdef ADSR_DONE_PULSE_EN
        .env_done(env_done),
`endif
        .active(active)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock; bench tracks its own prescaler phase to know tick edges.
    task automatic cyc();
        @(posedge clk);
        was_tick = (pc == PRE - 1);
        pc = was_tick ? 0 : pc + 1;
        @(negedge clk);
    endtask

    task automatic to_tick();
        for (int i = 0; i < PRE; i++) begin
            cyc();
            if (was_tick) return;
        end
    endtask

    task automatic expect_ls(input string tag, input logic [7:0] lvl, input logic [2:0] st);
        check({tag, "_level"}, env_level, lvl);
        check({tag, "_state"}, env_state, st);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; gate = 1'b0;
        attack_rate = 8'd64; decay_rate = 8'd32; sustain_level = 8'd128; release_rate = 8'd50;
        duty_in = 16'h8000;
        repeat (2) @(negedge clk);
        check("rst_duty", duty_out, 16'h0);
        expect_ls("rst", 8'd0, 3'd0);
        check("rst_active", active, 1'b0);
        reset = 1'b0; pc = 0;

        // 1: attack
        gate = 1'b1;
        cyc();
        expect_ls("rise", 8'd0, 3'd1);
        check("rise_active", active, 1'b1);
        to_tick(); expect_ls("att1", 8'd64, 3'd1);
        to_tick(); expect_ls("att2", 8'd128, 3'd1);
        to_tick(); expect_ls("att3", 8'd192, 3'd1);
        to_tick(); expect_ls("att4", 8'd255, 3'd2);

        // duty scaling and 1-clk input latency
        cyc(); check("duty_255", duty_out, 16'h7F80);
        duty_in = 16'hFFFF;
        cyc(); check("duty_full", duty_out, 16'hFEFF);
        duty_in = 16'h8000;

        // 2: decay / sustain
        to_tick(); expect_ls("dec1", 8'd223, 3'd2);
        to_tick(); expect_ls("dec2", 8'd191, 3'd2);
        to_tick(); expect_ls("dec3", 8'd159, 3'd2);
        to_tick(); expect_ls("sus", 8'd128, 3'd3);
        cyc(); check("duty_sus", duty_out, 16'h4000);
        sustain_level = 8'd100;
        cyc(); expect_ls("sus_track", 8'd100, 3'd3);
        sustain_level = 8'd128;
        cyc(); expect_ls("sus_back", 8'd128, 3'd3);

        // 3: release
        gate = 1'b0;
        cyc(); expect_ls("rel", 8'd128, 3'd4);
        to_tick(); expect_ls("rel1", 8'd78, 3'd4);
        to_tick(); expect_ls("rel2", 8'd28, 3'd4);
        to_tick(); expect_ls("rel3", 8'd0, 3'd0);
        check("rel_active", active, 1'b0);
`ifdef ADSR_DONE_PULSE_EN
        check("done_pulse", env_done, 1'b1);
        cyc(); check("done_clear", env_done, 1'b0);
`endif

        // 4: early release and retrigger
        gate = 1'b1;
        cyc(); expect_ls("r4_rise", 8'd0, 3'd1);
        to_tick(); expect_ls("r4_att1", 8'd64, 3'd1);
        to_tick(); expect_ls("r4_att2", 8'd128, 3'd1);
        gate = 1'b0;
        cyc(); expect_ls("r4_rel", 8'd128, 3'd4);
        to_tick(); expect_ls("r4_rel1", 8'd78, 3'd4);
        gate = 1'b1;
        cyc(); expect_ls("r4_retrig", 8'd78, 3'd1);
        to_tick(); expect_ls("r4_att3", 8'd142, 3'd1);
        to_tick(); expect_ls("r4_att4", 8'd206, 3'd1);
        to_tick(); expect_ls("r4_att5", 8'd255, 3'd2);

        // 5: async reset mid-decay, saturation
        to_tick(); expect_ls("r5_dec", 8'd223, 3'd2);
        reset = 1'b1;
        #1;
        expect_ls("r5_async", 8'd0, 3'd0);
        check("r5_duty", duty_out, 16'h0);
        check("r5_active", active, 1'b0);
        @(negedge clk);
        attack_rate = 8'd255; sustain_level = 8'd255;
        reset = 1'b0; pc = 0;
        cyc(); expect_ls("r5_rise", 8'd0, 3'd1);
        to_tick(); expect_ls("r5_sat", 8'd255, 3'd2);
        to_tick(); expect_ls("r5_sus", 8'd255, 3'd3);

        // 6: rise on a tick edge, rate-0 hold
        gate = 1'b0; release_rate = 8'd255;
        cyc(); expect_ls("r6_rel", 8'd255, 3'd4);
        to_tick(); expect_ls("r6_idle", 8'd0, 3'd0);
        while (pc != PRE - 1) cyc();
        gate = 1'b1;
        cyc();
        check("r6_tick_edge", was_tick, 1'b1);
        expect_ls("r6_rise_tick", 8'd0, 3'd1);
        to_tick(); expect_ls("r6_att", 8'd255, 3'd2);
        sustain_level = 8'd100; decay_rate = 8'd255;
        to_tick(); expect_ls("r6_sus", 8'd100, 3'd3);
        release_rate = 8'd0; gate = 1'b0;
        cyc(); expect_ls("r6_rel", 8'd100, 3'd4);
        for (int i = 0; i < 10; i++) begin
            to_tick(); expect_ls("r6_hold", 8'd100, 3'd4);
        end
        release_rate = 8'd100;
        to_tick(); expect_ls("r6_end", 8'd0, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
